// File: rtl/rns_pkg.sv
// ============================================================================
//  Module      : rns_pkg
//  Description : Shared constants and FSM state type for the mod-256/mod-129
//                RNS datapath and its binary reverse converter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package rns_pkg;

    localparam int unsigned MOD_A       = 256;
    localparam int unsigned MOD_B       = 129;
    localparam int unsigned INV_A_MOD_B = 64;
    localparam int unsigned HALF_RANGE  = 16512;
    localparam int unsigned FULL_RANGE  = 33024;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DIFF = 3'd1,
        DBL  = 3'd2,
        COMB = 3'd3,
        HOLD = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rns_mod129_dbl.sv
// ============================================================================
//  Module      : rns_mod129_dbl
//  Description : Combinational modular doubling, d_out = (2 * d_in) mod 129,
//                for d_in in 0..128.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rns_mod129_dbl
    import rns_pkg::*;
(
    input  logic [7:0] d_in,
    output logic [7:0] d_out
);

    logic [8:0] w_twice;
    logic [8:0] w_reduced;

    assign w_twice   = {d_in, 1'b0};
    assign w_reduced = (w_twice >= 9'(MOD_B)) ? (w_twice - 9'(MOD_B)) : w_twice;
    assign d_out     = 8'(w_reduced);

endmodule

`default_nettype wire

// File: rtl/rns_to_bin_crt.sv
// ============================================================================
//  Module      : rns_to_bin_crt
//  Description : Iterative two-modulus CRT reverse converter (mod 256, mod 129)
//                with valid/ready handshakes; fixed 8-cycle latency.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rns_to_bin_crt
    import rns_pkg::*;
#(
    parameter int RES_W = 8,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RES_W-1:0] r256,
    input  logic [RES_W-1:0] r129,
    input  logic             sgn_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] dout,
    output logic             err
);

    localparam int DBL_N = $clog2(INV_A_MOD_B);

    state_t           r_state;
    logic [2:0]       r_cnt;
    logic [RES_W-1:0] r_r256;
    logic [RES_W-1:0] r_r129;
    logic             r_sgn;
    logic             r_bad;
    logic [7:0]       r_d;

    logic [8:0]  w_a;
    logic [8:0]  w_diff;
    logic        w_bad;
    logic [7:0]  w_d_dbl;
    logic [15:0] w_x;
    logic [15:0] w_res;

    rns_mod129_dbl u_dbl (
        .d_in  (r_d),
        .d_out (w_d_dbl)
    );

    // (r129 - r256 mod 129) mod 129; the added MOD_B keeps the borrow case positive
    assign w_a    = (9'(r_r256) >= 9'(MOD_B)) ? (9'(r_r256) - 9'(MOD_B)) : 9'(r_r256);
    assign w_diff = (9'(r_r129) >= w_a) ? (9'(r_r129) - w_a)
                                        : (9'(r_r129) + 9'(MOD_B) - w_a);
    assign w_bad  = 9'(r_r129) > 9'(MOD_B - 1);

    assign w_x    = 16'(r_r256) + (16'(r_d) << $clog2(MOD_A));
    assign w_res  = (r_sgn && (w_x >= 16'(HALF_RANGE))) ? (w_x - 16'(FULL_RANGE)) : w_x;

    assign in_ready = (r_state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 3'd0;
            r_r256    <= '0;
            r_r129    <= '0;
            r_sgn     <= 1'b0;
            r_bad     <= 1'b0;
            r_d       <= 8'd0;
            out_valid <= 1'b0;
            dout      <= '0;
            err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_r256  <= r256;
                        r_r129  <= r129;
                        r_sgn   <= sgn_mode;
                        r_state <= DIFF;
                    end
                end
                DIFF: begin
                    r_bad   <= w_bad;
                    r_d     <= w_bad ? 8'd0 : 8'(w_diff);
                    r_cnt   <= 3'd0;
                    r_state <= DBL;
                end
                DBL: begin
                    r_d <= w_d_dbl;
                    if (r_cnt == 3'(DBL_N - 1)) begin
                        r_cnt   <= 3'd0;
                        r_state <= COMB;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                COMB: begin
                    dout      <= r_bad ? '0 : OUT_W'(w_res);
                    err       <= r_bad;
                    out_valid <= 1'b1;
                    r_state   <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
